forwarding_ctrl: RTL and testbench
==================================

FORWARDING_CTRL -- requirements
Module: forwarding_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: id_valid  in  1  the ID stage holds a real instruction.
REQ-005 Port: id_rs1, id_rs2  in  5 each  ID-stage source register numbers.
REQ-006 Port: id_rd  in  5  ID-stage destination register.
REQ-007 Port: id_reg_write, id_mem_read  in  1 each  ID-stage instruction writes a register / is a load.
REQ-008 Port: branch_taken  in  1  EX-stage branch resolved taken; flush request.
REQ-009 Port: ForwardA, ForwardB  out  2 each  select codes for the operand-A/B forwarding muxes: 00 = ID/EX data, 01 = EX/MEM data, 10 = MEM/WB data.
REQ-010 Port: pc_write, ifid_write  out  1 each  PC / IF-ID register enable, active high.
REQ-011 Port: idex_bubble  out  1  insert a NOP into ID/EX.
REQ-012 Port: ifid_flush  out  1  clear IF/ID.
REQ-013 Port: stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-014 The block SHALL hold three shadow stage registers (EX, MEM, WB); each holds {valid, rd, reg_write, mem_read}, and EX also holds {rs1, rs2}.
REQ-015 Every rising clk edge SHALL advance the shadows: WB<=MEM, MEM<=EX, EX<=ID inputs; if idex_bubble=1, EX SHALL instead load valid=0 with all other fields 0.
REQ-016 A shadow stage SHALL be a forwarding source only if valid=1, reg_write=1 and rd!=0.
REQ-017 ForwardA SHALL be combinational from the shadows only:
  - 01 if MEM is a source and MEM.rd==EX.rs1;
  - else 10 if WB is a source and WB.rd==EX.rs1;
  - else 00.
  ForwardB SHALL follow the same rule using EX.rs2.
REQ-018 When EX.valid=0, both ForwardA and ForwardB SHALL be 00.
REQ-019 The code 11 SHALL never be driven on ForwardA or ForwardB.
REQ-020 Load-use hazard (combinational) SHALL be asserted when all hold:
  - id_valid=1;
  - EX.valid=1, EX.mem_read=1, EX.rd!=0;
  - EX.rd==id_rs1 or EX.rd==id_rs2.
REQ-021 During a load-use hazard: pc_write=0, ifid_write=0, idex_bubble=1; this SHALL last exactly one cycle per load, because the bubble clears EX.valid.
REQ-022 When branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
REQ-023 Flush SHALL take priority over stall: when both are active the outputs SHALL follow REQ-022 and stall_count SHALL NOT increment.
REQ-024 With no hazard and no flush: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
REQ-025 stall_count SHALL increment by 1 on each clk edge where the REQ-021 stall is in effect, and SHALL saturate at 16'hFFFF without wrapping.
REQ-026 Hazard and forwarding logic SHALL depend only on current inputs and registered shadows, with no additional latency.

Reset
REQ-027 When rst_n=0, all shadow fields and stall_count SHALL clear to 0 immediately, independent of clk.
REQ-028 During reset and immediately after it: ForwardA=ForwardB=00, pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, unless branch_taken=1 is driven.
REQ-029 Reset asserted mid-stall SHALL drop the stall in the same delta; the first post-reset edge SHALL capture ID inputs normally.

Verification
REQ-030 EX/MEM forward: instruction A (rd=5, reg_write) followed by instruction B (rs1=5) -> when B is in EX, ForwardA=01 and ForwardB=00.
REQ-031 MEM/WB forward with priority: A (rd=7), B (rd=7), C (rs1=7, rs2=7) -> when C is in EX, ForwardA=ForwardB=01; with B's reg_write=0, both =10.
REQ-032 x0 guard: writer with rd=0 followed by a reader of rs1=0 -> ForwardA=00 in every cycle.
REQ-033 Load-use: load (rd=3, mem_read) followed by id_rs2=3 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_count goes 0->1; the next cycle gives ForwardB=10.
REQ-034 Flush beats stall: load-use condition with branch_taken=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, stall_count unchanged.
REQ-035 Saturation and reset: force stall_count to 16'hFFFF via repeated stalls, then stall again -> it stays at FFFF; pulse rst_n=0 between clock edges -> stall_count=0 and the shadows are cleared before the next edge.

Source files
------------

// File: rtl/forwarding_ctrl.sv
// Forwarding and hazard controller for a five-stage in-order pipeline.
// Tracks EX/MEM/WB shadows of the ID instruction and drives mux selects, stall and flush controls.
module forwarding_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        branch_taken,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  localparam logic [1:0] SEL_IDEX  = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  stage_t     ex_q, mem_q, wb_q;
  logic [4:0] ex_rs1_q, ex_rs2_q;
  logic       load_use;
  logic       stall;
  logic       unused_load_flags;

  function automatic logic is_source(input stage_t s);
    return s.valid && s.reg_write && (s.rd != 5'd0);
  endfunction

  // MEM is the younger producer, so it wins over WB when both match.
  function automatic logic [1:0] fwd_sel(input logic       ex_valid,
                                         input logic [4:0] rs,
                                         input stage_t     mem_s,
                                         input stage_t     wb_s);
    fwd_sel = SEL_IDEX;
    if (ex_valid) begin
      if (is_source(mem_s) && (mem_s.rd == rs))
        fwd_sel = SEL_EXMEM;
      else if (is_source(wb_s) && (wb_s.rd == rs))
        fwd_sel = SEL_MEMWB;
    end
  endfunction

  assign ForwardA = fwd_sel(ex_q.valid, ex_rs1_q, mem_q, wb_q);
  assign ForwardB = fwd_sel(ex_q.valid, ex_rs2_q, mem_q, wb_q);

  // Load results are not forwarded differently once past EX; the flags ride along for observability.
  assign unused_load_flags = mem_q.mem_read ^ wb_q.mem_read;

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    stall       = load_use && !branch_taken;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall || branch_taken;
    ifid_flush  = branch_taken;
  end

  // NOTE: non-blocking assignments make every shadow advance from its pre-edge value,
  // so WB<=MEM<=EX<=ID behaves as a true shift regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      stall_count <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (idex_bubble) begin
        ex_q     <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end else begin
        ex_q     <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
        ex_rs1_q <= id_rs1;
        ex_rs2_q <= id_rs2;
      end
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Self-checking bench for forwarding_ctrl: directed scenarios plus randomized traffic
// compared against a pipeline-history reference model.
module tb_forwarding_ctrl;

  logic        clk, rst_n, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read, branch_taken;
  logic [1:0]  ForwardA, ForwardB;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  forwarding_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hist[0] is the instruction now in EX, hist[1] the one before it, hist[2] the one before that.
  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr;
  } instr_t;

  localparam instr_t NOP = '0;

  instr_t      hist[3];
  instr_t      id_i;
  logic        br_i;
  int unsigned m_cnt;

  function automatic instr_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic mr);
    instr_t i;
    i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  // Nearest older instruction that writes a nonzero register equal to r supplies the operand.
  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (!hist[0].v) return 2'd0;
    for (int k = 1; k <= 2; k++)
      if (hist[k].v && hist[k].rw && hist[k].rd != 0 && hist[k].rd == r) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic m_load_use();
    return id_i.v && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
           (hist[0].rd == id_i.rs1 || hist[0].rd == id_i.rs2);
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) hist[k] = NOP;
    m_cnt = 0;
  endtask

  task automatic set_inputs(input instr_t i, input logic b);
    id_i = i; br_i = b;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_reg_write = i.rw; id_mem_read = i.mr; branch_taken = b;
  endtask

  task automatic apply(input instr_t i, input logic b);
    @(negedge clk);
    set_inputs(i, b);
    #1;
  endtask

  task automatic tick();
    logic stall;
    stall = m_load_use() && !br_i;
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = (stall || br_i) ? NOP : id_i;
    if (stall && m_cnt < 32'hFFFF) m_cnt++;
    #1;
  endtask

  task automatic drain();
    repeat (3) begin apply(NOP, 1'b0); tick(); end
  endtask

  task automatic test_reset();
    set_inputs(mk(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1), 1'b0);
    #2;
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL rst_fwdA: got %b want 00", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL rst_fwdB: got %b want 00", ForwardB); end
    n_cmp++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1100) begin n_err++;
      $display("FAIL rst_ctrl: got pc/ifid/bub/flush=%b want 1100", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %h want 0000", stall_count); end
    branch_taken = 1'b1;
    #1;
    n_cmp++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1111) begin n_err++;
      $display("FAIL rst_branch: got pc/ifid/bub/flush=%b want 1111", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
    branch_taken = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({ForwardA, ForwardB, idex_bubble} !== 5'b00000) begin n_err++;
      $display("FAIL rst_edge_hold: got fwdA/fwdB/bub=%b want 00000", {ForwardA, ForwardB, idex_bubble}); end
    set_inputs(NOP, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1100) begin n_err++;
      $display("FAIL post_rst_ctrl: got %b want 1100", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
  endtask

  task automatic test_ex_mem_fwd();
    drain();
    apply(mk(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0), 1'b0); tick();
    apply(mk(1'b1, 5'd5, 5'd9, 5'd10, 1'b0, 1'b0), 1'b0); tick();
    apply(NOP, 1'b0);
    n_cmp++; if (ForwardA !== 2'b01) begin n_err++; $display("FAIL exmem_fwdA: got %b want 01", ForwardA); end
    n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL exmem_fwdB: got %b want 00", ForwardB); end
    tick();
  endtask

  task automatic test_mem_wb_priority();
    logic [1:0] want;
    for (int bw = 1; bw >= 0; bw--) begin
      want = (bw == 1) ? 2'b01 : 2'b10;
      drain();
      apply(mk(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0), 1'b0); tick();
      apply(mk(1'b1, 5'd0, 5'd0, 5'd7, 1'(bw), 1'b0), 1'b0); tick();
      apply(mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0), 1'b0); tick();
      apply(NOP, 1'b0);
      n_cmp++; if (ForwardA !== want) begin n_err++; $display("FAIL prio_fwdA(bw=%0d): got %b want %b", bw, ForwardA, want); end
      n_cmp++; if (ForwardB !== want) begin n_err++; $display("FAIL prio_fwdB(bw=%0d): got %b want %b", bw, ForwardB, want); end
      tick();
    end
  endtask

  task automatic test_x0_guard();
    instr_t seq[4];
    drain();
    seq[0] = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    seq[1] = mk(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    seq[2] = NOP;
    seq[3] = NOP;
    for (int c = 0; c < 4; c++) begin
      apply(seq[c], 1'b0);
      n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL x0_fwdA(cycle %0d): got %b want 00", c, ForwardA); end
      tick();
    end
  endtask

  task automatic test_load_use();
    instr_t ld, dep;
    ld  = mk(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    dep = mk(1'b1, 5'd1, 5'd3, 5'd8, 1'b1, 1'b0);
    drain();
    apply(ld, 1'b0);
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL lu_count_before: got %h want 0000", stall_count); end
    tick();
    apply(dep, 1'b0);
    n_cmp++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b0010) begin n_err++;
      $display("FAIL lu_stall: got pc/ifid/bub/flush=%b want 0010", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
    tick();
    n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count_after: got %h want 0001", stall_count); end
    apply(dep, 1'b0);
    n_cmp++; if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin n_err++;
      $display("FAIL lu_one_cycle: got pc/ifid/bub=%b want 110", {pc_write, ifid_write, idex_bubble}); end
    tick();
    apply(NOP, 1'b0);
    n_cmp++; if (ForwardB !== 2'b10) begin n_err++; $display("FAIL lu_fwdB: got %b want 10", ForwardB); end
    n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL lu_fwdA: got %b want 00", ForwardA); end
    n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count_hold: got %h want 0001", stall_count); end
    tick();
  endtask

  task automatic test_flush_beats_stall();
    drain();
    apply(mk(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1), 1'b0); tick();
    apply(mk(1'b1, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0), 1'b1);
    n_cmp++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1111) begin n_err++;
      $display("FAIL flush_ctrl: got pc/ifid/bub/flush=%b want 1111", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
    tick();
    n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL flush_count: got %h want 0001", stall_count); end
  endtask

  task automatic test_random();
    instr_t r;
    logic   b, st;
    for (int n = 0; n < 2000; n++) begin
      r.v   = ($urandom_range(0, 7) != 0);
      r.rs1 = 5'($urandom_range(0, 7));
      r.rs2 = 5'($urandom_range(0, 7));
      r.rd  = 5'($urandom_range(0, 7));
      r.mr  = ($urandom_range(0, 2) == 0);
      r.rw  = r.mr | 1'($urandom_range(0, 1));
      b     = ($urandom_range(0, 15) == 0);
      apply(r, b);
      st = m_load_use() && !b;
      n_cmp++; if (ForwardA !== m_fwd(hist[0].rs1)) begin n_err++;
        $display("FAIL rnd_fwdA(%0d): got %b want %b", n, ForwardA, m_fwd(hist[0].rs1)); end
      n_cmp++; if (ForwardB !== m_fwd(hist[0].rs2)) begin n_err++;
        $display("FAIL rnd_fwdB(%0d): got %b want %b", n, ForwardB, m_fwd(hist[0].rs2)); end
      n_cmp++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== {!st, !st, st | b, b}) begin n_err++;
        $display("FAIL rnd_ctrl(%0d): got %b want %b", n, {pc_write, ifid_write, idex_bubble, ifid_flush}, {!st, !st, st | b, b}); end
      tick();
      n_cmp++; if (stall_count !== 16'(m_cnt)) begin n_err++;
        $display("FAIL rnd_count(%0d): got %h want %h", n, stall_count, 16'(m_cnt)); end
    end
  endtask

  task automatic test_saturation_reset();
    instr_t ld, dep;
    ld  = mk(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    dep = mk(1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0);
    drain();
    @(negedge clk);
    force dut.stall_count = 16'hFFFD;
    #1;
    release dut.stall_count;
    m_cnt = 32'hFFFD;
    n_cmp++; if (stall_count !== 16'hFFFD) begin n_err++; $display("FAIL sat_preload: got %h want fffd", stall_count); end
    for (int k = 0; k < 4; k++) begin
      apply(ld, 1'b0); tick();
      apply(dep, 1'b0); tick();
      n_cmp++; if (stall_count !== 16'(m_cnt)) begin n_err++;
        $display("FAIL sat_count(%0d): got %h want %h", k, stall_count, 16'(m_cnt)); end
    end
    n_cmp++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", stall_count); end
    drain();
    apply(mk(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0), 1'b0); tick();
    apply(mk(1'b1, 5'd4, 5'd0, 5'd3, 1'b1, 1'b1), 1'b0); tick();
    apply(mk(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0), 1'b0);
    n_cmp++; if ({idex_bubble, ForwardA} !== 3'b101) begin n_err++;
      $display("FAIL pre_rst_state: got bub/fwdA=%b want 101", {idex_bubble, ForwardA}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL midrst_count: got %h want 0000", stall_count); end
    n_cmp++; if ({ForwardA, pc_write, ifid_write, idex_bubble, ifid_flush} !== 6'b001100) begin n_err++;
      $display("FAIL midrst_ctrl: got fwdA/pc/ifid/bub/flush=%b want 001100", {ForwardA, pc_write, ifid_write, idex_bubble, ifid_flush}); end
    reset_model();
    rst_n = 1'b1;
    #1;
    tick();
    apply(mk(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0); tick();
    apply(NOP, 1'b0);
    n_cmp++; if (ForwardA !== 2'b01) begin n_err++; $display("FAIL postrst_capture: got %b want 01", ForwardA); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL postrst_count: got %h want 0000", stall_count); end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_inputs(NOP, 1'b0);
    reset_model();
    test_reset();
    test_ex_mem_fwd();
    test_mem_wb_priority();
    test_x0_guard();
    test_load_use();
    test_flush_beats_stall();
    test_random();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
